// File: rtl/bus_demux_if.sv
// Bundle of upstream request/response and two downstream port signals for bus_demux.
// Latency: none, wires only.
// Backpressure: req_ready and pk_ready carry it; the response path has none.
interface bus_demux_if;
  // upstream request
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_we;
  // upstream response
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  // downstream port 0
  logic        p0_valid;
  logic        p0_ready;
  logic [31:0] p0_addr;
  logic [31:0] p0_wdata;
  logic        p0_we;
  logic        p0_rsp_valid;
  logic [31:0] p0_rdata;
  // downstream port 1
  logic        p1_valid;
  logic        p1_ready;
  logic [31:0] p1_addr;
  logic [31:0] p1_wdata;
  logic        p1_we;
  logic        p1_rsp_valid;
  logic [31:0] p1_rdata;

  // Demux side: receives upstream requests, drives both downstream ports.
  modport slave (
    input  req_valid, req_addr, req_wdata, req_we,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output p0_valid, p0_addr, p0_wdata, p0_we,
    input  p0_ready, p0_rsp_valid, p0_rdata,
    output p1_valid, p1_addr, p1_wdata, p1_we,
    input  p1_ready, p1_rsp_valid, p1_rdata
  );

  // Environment side: issues requests upstream and plays both targets.
  modport master (
    output req_valid, req_addr, req_wdata, req_we,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  p0_valid, p0_addr, p0_wdata, p0_we,
    output p0_ready, p0_rsp_valid, p0_rdata,
    input  p1_valid, p1_addr, p1_wdata, p1_we,
    output p1_ready, p1_rsp_valid, p1_rdata
  );
endinterface

// File: rtl/bus_demux.sv
// Address-split demux: routes one outstanding request to port 0 or 1, returns the completion.
// Latency: 3 cycles best case (accept -> issue -> wait -> resp); one request per 4 cycles at most.
// Backpressure: req_ready only in IDLE; downstream ready stalls ISSUE; TIMEOUT cycles bound any stall.
module bus_demux #(
  parameter logic [31:0] SPLIT_BASE = 32'h1000_0000,
  parameter int          TIMEOUT    = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  bus_demux_if.slave bus
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_MAX  = CW'(TIMEOUT);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sel_q, sel_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          we_q, we_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;

  // Signals of whichever port the current transaction targets; the other port is never looked at.
  logic        sel_ready;
  logic        sel_rsp_valid;
  logic [31:0] sel_rdata;
  logic [CW-1:0] cnt_inc;
  logic        timeout_hit;

  assign sel_ready     = sel_q ? bus.p1_ready     : bus.p0_ready;
  assign sel_rsp_valid = sel_q ? bus.p1_rsp_valid : bus.p0_rsp_valid;
  assign sel_rdata     = sel_q ? bus.p1_rdata     : bus.p0_rdata;

  // Saturating count of cycles spent in ISSUE/WAIT. The limit is reached by the increment
  // taken in the current cycle, so the TIMEOUT-th busy cycle is the last one allowed.
  assign cnt_inc     = (cnt_q == TO_MAX) ? cnt_q : cnt_q + CW'(1);
  assign timeout_hit = (cnt_q >= TO_LAST);

  // State and datapath registers, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sel_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic; a completion in the same cycle as the timeout wins.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          we_d    = bus.req_we;
          sel_d   = (bus.req_addr >= SPLIT_BASE);
          cnt_d   = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d = cnt_inc;
        if (sel_ready) begin
          state_d = WAIT;
        end else if (timeout_hit) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      WAIT: begin
        cnt_d = cnt_inc;
        if (sel_rsp_valid) begin
          rdata_d = sel_rdata;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (timeout_hit) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

  // Both ports always see the latched request; only valid tells the target it is theirs.
  assign bus.p0_valid = (state_q == ISSUE) && !sel_q;
  assign bus.p1_valid = (state_q == ISSUE) &&  sel_q;
  assign bus.p0_addr  = addr_q;
  assign bus.p1_addr  = addr_q;
  assign bus.p0_wdata = wdata_q;
  assign bus.p1_wdata = wdata_q;
  assign bus.p0_we    = we_q;
  assign bus.p1_we    = we_q;

endmodule

// File: tb/tb_bus_demux.sv
// Randomized and directed checks of bus_demux against a transaction-level timing model.
// Latency: n/a.
// Backpressure: the bench plays both targets, stalling ready and completions as scripted.
module tb_bus_demux;

  localparam logic [31:0] SPLIT = 32'h1000_0000;
  localparam int          TO    = 15;
  localparam int          NEVER = 1000;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  bus_demux_if bif ();

  bus_demux #(.SPLIT_BASE(SPLIT), .TIMEOUT(TO)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle_targets();
    bif.p0_ready = 1'b0; bif.p0_rsp_valid = 1'b0; bif.p0_rdata = '0;
    bif.p1_ready = 1'b0; bif.p1_rsp_valid = 1'b0; bif.p1_rdata = '0;
  endtask

  // One transaction, starting and ending at a negedge in IDLE.
  // d_r: cycles the target holds ready low before raising it; d_s: cycles from handshake
  // to completion. Expected outcome is derived from cycle counts alone: cycle c is the c-th
  // cycle after the accepting edge; at most TO busy cycles are allowed, the response shows
  // the cycle after the last busy one.
  task automatic run_txn(input logic [31:0] addr, input logic [31:0] wdata, input logic we,
                         input int d_r, input int d_s, input logic [31:0] data, input bit stray);
    bit          sel;
    int          ready_c, rsp_c, exp_c, valid_end;
    logic        exp_err;
    logic [31:0] exp_data;
    logic        s_ready, s_rsp, o_ready, o_rsp;
    logic [31:0] s_rdata, o_rdata;

    sel     = (addr >= SPLIT);
    ready_c = (d_r + 1 <= TO) ? d_r + 1 : 0;
    if (ready_c != 0 && ready_c + d_s + 1 <= TO) begin
      rsp_c    = ready_c + d_s + 1;
      exp_c    = rsp_c + 1;
      exp_err  = 1'b0;
      exp_data = data;
    end else begin
      rsp_c    = 0;
      exp_c    = TO + 1;
      exp_err  = 1'b1;
      exp_data = '0;
    end
    valid_end = (ready_c != 0) ? ready_c : TO;

    chk("req_ready_idle", bif.req_ready, 1);
    bif.req_valid = 1'b1;
    bif.req_addr  = addr;
    bif.req_wdata = wdata;
    bif.req_we    = we;
    idle_targets();
    @(negedge clk);
    bif.req_valid = 1'b0;
    bif.req_addr  = $urandom;
    bif.req_wdata = $urandom;

    for (int c = 1; c <= exp_c; c++) begin
      s_ready = (c == ready_c) ||
                (stray && ready_c != 0 && c > ready_c && ($urandom_range(1) == 1));
      s_rsp   = (rsp_c != 0 && c == rsp_c) ||
                (stray && (ready_c == 0 || c <= ready_c || c >= exp_c) && ($urandom_range(1) == 1));
      s_rdata = (c == rsp_c) ? data : $urandom;
      o_ready = stray && ($urandom_range(1) == 1);
      o_rsp   = stray && ($urandom_range(1) == 1);
      o_rdata = 32'hFFFF_FFFF;
      if (sel) begin
        bif.p1_ready = s_ready; bif.p1_rsp_valid = s_rsp; bif.p1_rdata = s_rdata;
        bif.p0_ready = o_ready; bif.p0_rsp_valid = o_rsp; bif.p0_rdata = o_rdata;
      end else begin
        bif.p0_ready = s_ready; bif.p0_rsp_valid = s_rsp; bif.p0_rdata = s_rdata;
        bif.p1_ready = o_ready; bif.p1_rsp_valid = o_rsp; bif.p1_rdata = o_rdata;
      end

      chk("req_ready_busy", bif.req_ready, 0);
      chk("p0_valid", bif.p0_valid, (!sel && c <= valid_end) ? 1 : 0);
      chk("p1_valid", bif.p1_valid, ( sel && c <= valid_end) ? 1 : 0);
      chk("p0_addr", bif.p0_addr, addr);
      chk("p1_wdata", bif.p1_wdata, wdata);
      chk("pk_we", sel ? bif.p1_we : bif.p0_we, we);
      chk("rsp_valid", bif.rsp_valid, (c == exp_c) ? 1 : 0);
      if (c == exp_c) begin
        chk("rsp_rdata", bif.rsp_rdata, exp_data);
        chk("rsp_err", bif.rsp_err, exp_err);
      end
      @(negedge clk);
    end
    idle_targets();
    chk("rsp_valid_after", bif.rsp_valid, 0);
    chk("rsp_rdata_hold", bif.rsp_rdata, exp_data);
    chk("rsp_err_hold", bif.rsp_err, exp_err);
    chk("req_ready_after", bif.req_ready, 1);
  endtask

  initial begin
    logic [31:0] a;
    int          dr, ds;
    n_checks = 0;
    n_fail   = 0;
    rst_n         = 1'b0;
    bif.req_valid = 1'b0;
    bif.req_addr  = '0;
    bif.req_wdata = '0;
    bif.req_we    = 1'b0;
    idle_targets();

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_p0_valid", bif.p0_valid, 0);
    chk("rst_p1_valid", bif.p1_valid, 0);
    chk("rst_rsp_valid", bif.rsp_valid, 0);
    chk("rst_rsp_rdata", bif.rsp_rdata, 0);
    chk("rst_rsp_err", bif.rsp_err, 0);
    chk("rst_p0_addr", bif.p0_addr, 0);
    chk("rst_p1_wdata", bif.p1_wdata, 0);
    chk("rst_p1_we", bif.p1_we, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_release_ready", bif.req_ready, 1);

    // load to port 0, best case
    run_txn(32'h0000_0040, 32'h0, 1'b0, 0, 0, 32'hDEAD_BEEF, 1'b0);
    // store to port 1 at the boundary, ready withheld 4 cycles
    run_txn(SPLIT, 32'h1234_5678, 1'b1, 4, 1, 32'hCAFE_0001, 1'b0);
    // just below the boundary goes to port 0
    run_txn(SPLIT - 1, 32'hA5A5_A5A5, 1'b1, 1, 2, 32'h0BAD_F00D, 1'b0);
    // timeout in WAIT, then in ISSUE
    run_txn(32'h0000_1000, 32'h1, 1'b0, 0, NEVER, 32'h1111_1111, 1'b0);
    run_txn(32'hFFFF_FFFC, 32'h2, 1'b1, NEVER, 0, 32'h2222_2222, 1'b0);
    // stray traffic on port 1 during a port 0 transaction
    run_txn(32'h0000_0200, 32'h3, 1'b0, 2, 5, 32'h3333_3333, 1'b1);
    // completion in the last allowed cycle wins; one cycle later is a timeout
    run_txn(32'h0000_0300, 32'h4, 1'b0, 0, 13, 32'h4444_4444, 1'b0);
    run_txn(32'h2000_0000, 32'h5, 1'b0, 0, 14, 32'h5555_5555, 1'b0);
    run_txn(32'h0000_0400, 32'h6, 1'b0, 0, 0, 32'h6666_6666, 1'b0);

    // reset while in WAIT aborts the transaction
    bif.req_valid = 1'b1; bif.req_addr = 32'h0000_0080; bif.req_we = 1'b0;
    @(negedge clk);
    bif.req_valid = 1'b0; bif.p0_ready = 1'b1;
    @(negedge clk);
    bif.p0_ready = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_p0_valid", bif.p0_valid, 0);
    chk("mid_rst_rsp_valid", bif.rsp_valid, 0);
    chk("mid_rst_req_ready", bif.req_ready, 1);
    chk("mid_rst_rsp_rdata", bif.rsp_rdata, 0);
    chk("mid_rst_p0_addr", bif.p0_addr, 0);
    bif.p0_rsp_valid = 1'b1; bif.p0_rdata = 32'h7777_7777;
    @(negedge clk);
    chk("mid_rst_rsp_valid2", bif.rsp_valid, 0);
    rst_n = 1'b1;
    bif.p0_rsp_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_rsp_valid", bif.rsp_valid, 0);
    run_txn(32'h0000_0080, 32'h8, 1'b0, 0, 0, 32'h8888_8888, 1'b0);

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(3))
        0: a = SPLIT;
        1: a = SPLIT - 1;
        default: a = $urandom;
      endcase
      dr = ($urandom_range(9) == 0) ? NEVER : int'($urandom_range(6));
      ds = ($urandom_range(4) == 0) ? NEVER : int'($urandom_range(11));
      run_txn(a, $urandom, 1'($urandom_range(1)), dr, ds, $urandom, 1'($urandom_range(1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_demux.md
BUS_DEMUX -- requirements
Module: bus_demux

Interface
REQ-001 SHALL have parameter SPLIT_BASE, default 32'h1000_0000: addresses >= SPLIT_BASE route to port 1, all others to port 0.
REQ-002 SHALL have parameter TIMEOUT, default 15: the maximum number of cycles to wait for a downstream completion.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-005 SHALL have upstream request ports:
- req_valid, input, 1 bit.
- req_ready, output, 1 bit.
- req_addr, input, 32 bits.
- req_wdata, input, 32 bits.
- req_we, input, 1 bit: 1 = store, 0 = load.
REQ-006 SHALL have upstream response ports:
- rsp_valid, output, 1 bit.
- rsp_rdata, output, 32 bits.
- rsp_err, output, 1 bit.
REQ-007 SHALL have, for each downstream port k in {0,1}:
- pk_valid, output, 1 bit.
- pk_ready, input, 1 bit.
- pk_addr, output, 32 bits.
- pk_wdata, output, 32 bits.
- pk_we, output, 1 bit.
- pk_rsp_valid, input, 1 bit.
- pk_rdata, input, 32 bits.

Function
REQ-008 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP, with one transaction outstanding at most.
REQ-009 In IDLE, req_ready SHALL be 1; in all other states it SHALL be 0.
REQ-010 In IDLE, when req_valid=1, the block SHALL do the following and enter ISSUE:
- latch addr, wdata and we;
- latch sel = (req_addr >= SPLIT_BASE), compared as unsigned;
- clear the timeout counter.
REQ-011 In ISSUE, only port p_sel SHALL drive valid=1, carrying the latched addr, wdata and we; the other port's valid SHALL be 0.
REQ-012 Address, data and we outputs of both ports SHALL hold the latched values in all states; only valid qualifies them.
REQ-013 In ISSUE, when p_sel ready=1 in the same cycle as valid=1, the block SHALL go to WAIT the next cycle; valid SHALL drop to 0 in WAIT.
REQ-014 In WAIT, when p_sel rsp_valid=1, the block SHALL do the following and go to RESP:
- capture p_sel rdata (captured for stores too);
- clear the error flag.
REQ-015 rsp_valid and pk_ready from the unselected port, and rsp_valid from any port outside WAIT, SHALL be ignored.
REQ-016 The timeout counter SHALL increment by 1 each cycle in ISSUE and WAIT, and SHALL saturate at TIMEOUT.
REQ-017 When the counter equals TIMEOUT with no completion in that cycle, the block SHALL go to RESP with error=1 and rdata=0. In ISSUE, valid SHALL be withdrawn.
REQ-018 If completion and the timeout coincide in the same cycle, completion SHALL win: err=0 and the data is captured.
REQ-019 In RESP, rsp_valid SHALL be 1 for exactly one cycle, with rsp_rdata and rsp_err valid. The next state SHALL be IDLE; upstream has no backpressure on the response.
REQ-020 Outside RESP, rsp_valid SHALL be 0; rsp_rdata and rsp_err SHALL hold their last values.
REQ-021 Best-case latency SHALL be 3 cycles from the accepting edge to the rsp_valid cycle: accept at edge T, ISSUE with ready at T+1, rsp at T+2, rsp_valid during T+3.
REQ-022 Back-to-back requests SHALL be accepted no faster than one per 4 cycles.

Reset
REQ-023 While rst_n=0 at a rising edge, the block SHALL set the state to IDLE, zero the counter, and zero the latched sel, addr, wdata, we, rdata and err.
REQ-024 During and after reset, the following outputs SHALL be 0, and req_ready SHALL be 1 in the first cycle after reset release:
- p0_valid, p1_valid and rsp_valid;
- rsp_rdata and rsp_err;
- all pk_addr, pk_wdata and pk_we.
REQ-025 Reset asserted mid-transaction, in any state, SHALL abort it with no response issued; pk_valid SHALL drop at the next edge.

Verification
REQ-026 Load to port 0: req addr=32'h0000_0040, we=0; p0_ready=1 immediately; p0_rsp_valid=1 with rdata=32'hDEAD_BEEF one cycle later. Required:
- p1_valid stays 0;
- rsp_valid pulses 3 cycles after accept with rdata=DEAD_BEEF, err=0.
REQ-027 Store to port 1 at the boundary: addr=32'h1000_0000, wdata=32'h1234_5678, we=1; p1_ready held 0 for 4 cycles, then 1. Required:
- p1_valid held with stable addr, wdata and we for 5 cycles;
- the response arrives after the p1 completion.
REQ-028 Timeout: port 0 selected; p0_rsp_valid never asserted. Required: rsp_valid with err=1 and rdata=0 occurs 16 cycles after accept (15 counting + RESP); req_ready returns to 1 the cycle after.
REQ-029 Stray traffic: during a port 0 WAIT, pulse p1_rsp_valid=1 with rdata=32'hFFFF_FFFF. Required: the pulse is ignored, and the later p0 completion returns the p0 data.
REQ-030 Mid-flight reset: assert rst_n=0 in WAIT. Required:
- the next cycle shows IDLE outputs, with rsp_valid never pulsed;
- a new request completes normally after release.
REQ-031 Simultaneous completion and timeout: p0_rsp_valid=1 in the cycle the counter reaches 15. Required: err=0 and the data is returned.
